// File: rtl/net_handshake_ctrl.sv
// net_handshake_ctrl: arbitrates processor send/receive requests (round-robin
// on ties), runs the four-phase flag handshake with the Arduino, synchronises
// the asynchronous Arduino inputs, and aborts any wait phase that stalls for
// TIMEOUT cycles.
module net_handshake_ctrl #(
  parameter int TIMEOUT = 1000000,
  parameter int TO_W    = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       reqSend,
  input  logic [1:0] sendDest,
  input  logic [3:0] sendData,
  input  logic       reqReceive,
  output logic       flagSendArduino,
  output logic [1:0] destToArduino,
  output logic [3:0] dataToArduino,
  input  logic       flagSentArduino,
  output logic       flagReceiveArduino,
  input  logic       flagReceivedArduino,
  input  logic [3:0] dataFromArduino,
  output logic       busy,
  output logic       sendDone,
  output logic       recvDone,
  output logic [3:0] recvData,
  output logic       timeoutErr
);

  typedef enum logic [2:0] {IDLE, S_REQ, S_REL, R_REQ, R_REL} state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic            s_ack_p0, s_ack_p1;
  logic            r_ack_p0, r_ack_p1;
  logic [3:0]      r_data_p0, r_data_p1;
  state_t          state;
  logic            last_grant_recv;
  logic [TO_W-1:0] to_cnt;
  logic            to_hit;

  assign to_hit = (to_cnt == TO_LAST);

  // Two-flop synchronisers; only the _p1 copies are seen by the FSM
  always_ff @(posedge clock) begin
    if (reset) begin
      s_ack_p0  <= 1'b0;
      s_ack_p1  <= 1'b0;
      r_ack_p0  <= 1'b0;
      r_ack_p1  <= 1'b0;
      r_data_p0 <= '0;
      r_data_p1 <= '0;
    end else begin
      s_ack_p0  <= flagSentArduino;
      s_ack_p1  <= s_ack_p0;
      r_ack_p0  <= flagReceivedArduino;
      r_ack_p1  <= r_ack_p0;
      r_data_p0 <= dataFromArduino;
      r_data_p1 <= r_data_p0;
    end
  end

  // Arbitration, handshake sequencing and per-phase timeout with registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state              <= IDLE;
      last_grant_recv    <= 1'b1;
      to_cnt             <= '0;
      flagSendArduino    <= 1'b0;
      flagReceiveArduino <= 1'b0;
      destToArduino      <= '0;
      dataToArduino      <= '0;
      busy               <= 1'b0;
      sendDone           <= 1'b0;
      recvDone           <= 1'b0;
      recvData           <= '0;
      timeoutErr         <= 1'b0;
    end else begin
      sendDone   <= 1'b0;
      recvDone   <= 1'b0;
      timeoutErr <= 1'b0;
      case (state)
        IDLE: begin
          to_cnt <= '0;
          // On a tie, send wins only if the previous grant went to receive
          if (reqSend && (!reqReceive || last_grant_recv)) begin
            destToArduino   <= sendDest;
            dataToArduino   <= sendData;
            flagSendArduino <= 1'b1;
            busy            <= 1'b1;
            last_grant_recv <= 1'b0;
            state           <= S_REQ;
          end else if (reqReceive) begin
            flagReceiveArduino <= 1'b1;
            busy               <= 1'b1;
            last_grant_recv    <= 1'b1;
            state              <= R_REQ;
          end
        end
        S_REQ: begin
          if (s_ack_p1) begin
            flagSendArduino <= 1'b0;
            to_cnt          <= '0;
            state           <= S_REL;
          end else if (to_hit) begin
            flagSendArduino    <= 1'b0;
            flagReceiveArduino <= 1'b0;
            timeoutErr         <= 1'b1;
            busy               <= 1'b0;
            to_cnt             <= '0;
            state              <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_REL: begin
          if (!s_ack_p1) begin
            sendDone <= 1'b1;
            busy     <= 1'b0;
            to_cnt   <= '0;
            state    <= IDLE;
          end else if (to_hit) begin
            flagSendArduino    <= 1'b0;
            flagReceiveArduino <= 1'b0;
            timeoutErr         <= 1'b1;
            busy               <= 1'b0;
            to_cnt             <= '0;
            state              <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        R_REQ: begin
          if (r_ack_p1) begin
            recvData           <= r_data_p1;
            flagReceiveArduino <= 1'b0;
            to_cnt             <= '0;
            state              <= R_REL;
          end else if (to_hit) begin
            flagSendArduino    <= 1'b0;
            flagReceiveArduino <= 1'b0;
            timeoutErr         <= 1'b1;
            busy               <= 1'b0;
            to_cnt             <= '0;
            state              <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        R_REL: begin
          if (!r_ack_p1) begin
            recvDone <= 1'b1;
            busy     <= 1'b0;
            to_cnt   <= '0;
            state    <= IDLE;
          end else if (to_hit) begin
            flagSendArduino    <= 1'b0;
            flagReceiveArduino <= 1'b0;
            timeoutErr         <= 1'b1;
            busy               <= 1'b0;
            to_cnt             <= '0;
            state              <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: begin
          flagSendArduino    <= 1'b0;
          flagReceiveArduino <= 1'b0;
          busy               <= 1'b0;
          to_cnt             <= '0;
          state              <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_net_handshake_ctrl.sv
// tb_net_handshake_ctrl: directed and randomized transactions against a
// transaction-level model of the arbiter (grant choice, captured values,
// received nibble, expected pulse counts) with an Arduino responder.
module tb_net_handshake_ctrl;

  localparam int TIMEOUT = 16;
  localparam int TO_W    = 5;

  logic       clock = 1'b0;
  logic       reset;
  logic       reqSend;
  logic [1:0] sendDest;
  logic [3:0] sendData;
  logic       reqReceive;
  logic       flagSendArduino;
  logic [1:0] destToArduino;
  logic [3:0] dataToArduino;
  logic       flagSentArduino;
  logic       flagReceiveArduino;
  logic       flagReceivedArduino;
  logic [3:0] dataFromArduino;
  logic       busy;
  logic       sendDone;
  logic       recvDone;
  logic [3:0] recvData;
  logic       timeoutErr;

  net_handshake_ctrl #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clock(clock), .reset(reset),
    .reqSend(reqSend), .sendDest(sendDest), .sendData(sendData),
    .reqReceive(reqReceive),
    .flagSendArduino(flagSendArduino), .destToArduino(destToArduino),
    .dataToArduino(dataToArduino), .flagSentArduino(flagSentArduino),
    .flagReceiveArduino(flagReceiveArduino), .flagReceivedArduino(flagReceivedArduino),
    .dataFromArduino(dataFromArduino), .busy(busy),
    .sendDone(sendDone), .recvDone(recvDone), .recvData(recvData),
    .timeoutErr(timeoutErr)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  bit started = 1'b0;

  // Observed pulse counts and the counts the model expects
  int n_send_done = 0, n_recv_done = 0, n_err = 0;
  int exp_send_done = 0, exp_recv_done = 0, exp_err = 0;

  // Transaction-level model state
  bit         model_last_recv;
  logic [3:0] model_recv;
  logic [1:0] model_dest;
  logic [3:0] model_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Pulse counting and mutual exclusion of the two strobes
  always @(negedge clock) begin
    if (started) begin
      if (sendDone === 1'b1)   n_send_done++;
      if (recvDone === 1'b1)   n_recv_done++;
      if (timeoutErr === 1'b1) n_err++;
      check("flags_exclusive", {31'b0, flagSendArduino & flagReceiveArduino}, 32'd0);
    end
  end

  // Present requests at an IDLE sample point; one edge later the model's grant must show
  task automatic grant(input bit rs, input bit rr, input logic [1:0] dest, input logic [3:0] data,
                       input bit hold, output bit is_send);
    reqSend = rs; reqReceive = rr; sendDest = dest; sendData = data;
    tick();
    is_send = rs && (!rr || model_last_recv);
    model_last_recv = !is_send;
    check("grant_flag_send", flagSendArduino, is_send);
    check("grant_flag_recv", flagReceiveArduino, !is_send);
    check("grant_busy", busy, 1);
    check("grant_no_pulse", {sendDone, recvDone, timeoutErr}, 0);
    if (is_send) begin
      model_dest = dest;
      model_data = data;
    end
    check("grant_dest", destToArduino, model_dest);
    check("grant_data", dataToArduino, model_data);
    if (!hold) begin
      reqSend = 1'b0; reqReceive = 1'b0;
      sendDest = 2'($urandom); sendData = 4'($urandom);
    end
  endtask

  // Arduino side of a send; entered at the sample where flagSendArduino just rose
  task automatic send_txn(input int d_ack, input int d_rel);
    for (int i = 0; i < d_ack; i++) begin
      tick();
      check("s_req_flag", flagSendArduino, 1);
      check("s_req_err", timeoutErr, 0);
    end
    flagSentArduino = 1'b1;
    tick(); check("s_ack_sync1", flagSendArduino, 1);
    tick(); check("s_ack_sync2", flagSendArduino, 1);
    tick();
    check("s_rel_flag", flagSendArduino, 0);
    check("s_rel_busy", busy, 1);
    check("s_rel_err", timeoutErr, 0);
    for (int i = 0; i < d_rel; i++) begin
      tick();
      check("s_rel_wait_busy", busy, 1);
      check("s_rel_wait_done", sendDone, 0);
      check("s_rel_wait_dest", destToArduino, model_dest);
      check("s_rel_wait_data", dataToArduino, model_data);
    end
    flagSentArduino = 1'b0;
    tick(); check("s_done_early1", sendDone, 0);
    tick(); check("s_done_early2", sendDone, 0);
    tick();
    check("s_done_pulse", sendDone, 1);
    check("s_done_busy", busy, 0);
    check("s_done_err", timeoutErr, 0);
    exp_send_done++;
  endtask

  // Arduino side of a receive; entered at the sample where flagReceiveArduino just rose
  task automatic recv_txn(input int d_ack, input int d_rel, input logic [3:0] nib);
    dataFromArduino = nib;
    for (int i = 0; i < d_ack; i++) begin
      tick();
      check("r_req_flag", flagReceiveArduino, 1);
      check("r_req_old_data", recvData, model_recv);
    end
    flagReceivedArduino = 1'b1;
    tick(); check("r_ack_sync1", recvData, model_recv);
    tick(); check("r_ack_sync2", recvData, model_recv);
    tick();
    model_recv = nib;
    check("r_rel_flag", flagReceiveArduino, 0);
    check("r_rel_data", recvData, model_recv);
    check("r_rel_busy", busy, 1);
    for (int i = 0; i < d_rel; i++) begin
      tick();
      check("r_rel_wait_done", recvDone, 0);
    end
    flagReceivedArduino = 1'b0;
    dataFromArduino = ~nib;
    tick(); check("r_done_early1", recvDone, 0);
    tick(); check("r_done_early2", recvDone, 0);
    tick();
    check("r_done_pulse", recvDone, 1);
    check("r_done_busy", busy, 0);
    check("r_done_hold", recvData, model_recv);
    check("r_done_err", timeoutErr, 0);
    exp_recv_done++;
  endtask

  // Leave the done/error sample: the pulse must be gone and the block idle
  task automatic idle_tick();
    tick();
    check("idle_pulses", {sendDone, recvDone, timeoutErr}, 0);
    check("idle_busy", busy, 0);
    check("idle_flags", {flagSendArduino, flagReceiveArduino}, 0);
  endtask

  task automatic model_reset();
    model_last_recv = 1'b1;
    model_recv = '0;
    model_dest = '0;
    model_data = '0;
  endtask

  initial begin
    bit   is_send;
    int   hi;
    int   guard;
    logic [3:0] nib;

    reset = 1'b1; reqSend = 1'b0; reqReceive = 1'b0; sendDest = '0; sendData = '0;
    flagSentArduino = 1'b0; flagReceivedArduino = 1'b0; dataFromArduino = '0;
    model_reset();
    tick(); tick();
    started = 1'b1;

    // Reset state
    check("rst_flags", {flagSendArduino, flagReceiveArduino}, 0);
    check("rst_busy", busy, 0);
    check("rst_pulses", {sendDone, recvDone, timeoutErr}, 0);
    check("rst_recvData", recvData, 0);
    check("rst_dest", destToArduino, 0);
    check("rst_data", dataToArduino, 0);
    reset = 1'b0;
    tick();
    check("post_rst_busy", busy, 0);

    // Directed send
    grant(1'b1, 1'b0, 2'd2, 4'hA, 1'b0, is_send);
    check("dir_send_dest", destToArduino, 2);
    check("dir_send_data", dataToArduino, 4'hA);
    send_txn(3, 3);
    idle_tick();
    check("dir_send_dest_held", destToArduino, 2);

    // Directed receive
    grant(1'b0, 1'b1, 2'd0, 4'h0, 1'b0, is_send);
    recv_txn(2, 3, 4'h5);
    idle_tick();
    repeat (3) tick();
    check("dir_recv_held", recvData, 4'h5);

    // Arbitration from reset: both requests held high
    reset = 1'b1; tick(); reset = 1'b0; model_reset(); tick();
    for (int i = 0; i < 4; i++) begin
      grant(1'b1, 1'b1, 2'(i), 4'(i + 7), 1'b1, is_send);
      check("arb_order", is_send, (i % 2 == 0) ? 1 : 0);
      if (is_send) send_txn($urandom_range(4, 0), $urandom_range(4, 0));
      else         recv_txn($urandom_range(4, 0), $urandom_range(4, 0), 4'($urandom));
      check("arb_idle_gap", busy, 0);
    end
    reqSend = 1'b0; reqReceive = 1'b0;
    idle_tick();

    // Send timeout: no acknowledge ever arrives
    grant(1'b1, 1'b0, 2'd1, 4'h3, 1'b0, is_send);
    hi = 1; guard = 0;
    while (flagSendArduino === 1'b1 && guard < 40) begin
      tick(); guard++;
      if (flagSendArduino === 1'b1) hi++;
    end
    check("to_send_flag_cycles", hi, TIMEOUT);
    check("to_send_err", timeoutErr, 1);
    check("to_send_no_done", sendDone, 0);
    check("to_send_busy", busy, 0);
    exp_err++;
    idle_tick();

    // Acknowledge seen on the last allowed cycle of each phase: exit wins
    grant(1'b1, 1'b0, 2'd3, 4'hC, 1'b0, is_send);
    send_txn(TIMEOUT - 3, TIMEOUT - 3);
    idle_tick();

    // Receive timeout: recvData must keep its previous value
    grant(1'b0, 1'b1, 2'd0, 4'h0, 1'b0, is_send);
    dataFromArduino = 4'($urandom);
    hi = 1; guard = 0;
    while (flagReceiveArduino === 1'b1 && guard < 40) begin
      tick(); guard++;
      if (flagReceiveArduino === 1'b1) hi++;
    end
    check("to_recv_flag_cycles", hi, TIMEOUT);
    check("to_recv_err", timeoutErr, 1);
    check("to_recv_no_done", recvDone, 0);
    check("to_recv_data_kept", recvData, model_recv);
    exp_err++;
    idle_tick();

    // A timed-out receive still counts as the last grant: send wins the tie
    grant(1'b1, 1'b1, 2'd1, 4'h6, 1'b0, is_send);
    check("tie_after_timeout", is_send, 1);
    send_txn(1, 1);
    idle_tick();

    // Reset during S_REQ drops the strobe on the next edge
    grant(1'b1, 1'b0, 2'd2, 4'h9, 1'b0, is_send);
    reset = 1'b1;
    tick();
    check("rst_sreq_flag", flagSendArduino, 0);
    check("rst_sreq_busy", busy, 0);
    reset = 1'b0; model_reset();
    tick();

    // Reset during R_REL
    grant(1'b0, 1'b1, 2'd0, 4'h0, 1'b0, is_send);
    dataFromArduino = 4'h9;
    flagReceivedArduino = 1'b1;
    tick(); tick(); tick();
    check("rrel_entered", flagReceiveArduino, 0);
    check("rrel_data", recvData, 4'h9);
    reset = 1'b1;
    tick();
    check("rst_rrel_flags", {flagSendArduino, flagReceiveArduino}, 0);
    check("rst_rrel_recvData", recvData, 0);
    check("rst_rrel_pulses", {sendDone, recvDone, timeoutErr}, 0);
    check("rst_rrel_busy", busy, 0);
    reset = 1'b0; flagReceivedArduino = 1'b0; dataFromArduino = '0;
    model_reset();
    repeat (4) idle_tick();
    grant(1'b1, 1'b1, 2'd1, 4'hE, 1'b0, is_send);
    check("rst_tie_send_first", is_send, 1);
    send_txn(2, 2);
    idle_tick();

    // Randomized traffic against the model
    for (int i = 0; i < 10; i++) begin
      int sel;
      sel = $urandom_range(2, 0);
      nib = 4'($urandom);
      grant(sel != 1, sel != 0, 2'($urandom), 4'($urandom), 1'b0, is_send);
      if (is_send) send_txn($urandom_range(10, 0), $urandom_range(10, 0));
      else         recv_txn($urandom_range(10, 0), $urandom_range(10, 0), nib);
      idle_tick();
    end

    // Pulse totals seen over the whole run
    check("total_send_done", n_send_done, exp_send_done);
    check("total_recv_done", n_recv_done, exp_recv_done);
    check("total_timeout_err", n_err, exp_err);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
